// File: rtl/udma_qspi_target.sv
// rtl/udma_qspi_target.sv - mode-0 single-lane SPI target, oversampled in clk_i, with rx/tx byte streams.
package udma_qspi_pkg;
    typedef struct packed {
        logic clk_o;
        logic csn0_o;
        logic csn1_o;
        logic csn2_o;
        logic csn3_o;
        logic oen0_o;
        logic oen1_o;
        logic oen2_o;
        logic oen3_o;
        logic sd0_o;
        logic sd1_o;
        logic sd2_o;
        logic sd3_o;
    } qspi_to_pad_t;

    typedef struct packed {
        logic sd0_i;
        logic sd1_i;
        logic sd2_i;
        logic sd3_i;
    } pad_to_qspi_t;
endpackage

module udma_qspi_target
    import udma_qspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  qspi_to_pad_t qspi_i,
    output pad_to_qspi_t qspi_o,
    output logic [7:0]   rx_data_o,
    output logic         rx_valid_o,
    input  logic         rx_ready_i,
    input  logic [7:0]   tx_data_i,
    input  logic         tx_valid_i,
    output logic         tx_ready_o,
    output logic         cs_active_o,
    output logic         rx_overrun_o,
    output logic         tx_underrun_o
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, csn_hist_q, mosi_hist_q;
    logic [SYNC_STAGES:0]   flush_q, flush_d;
    logic                   armed_q, armed_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   load_pending_q, load_pending_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overrun_q, rx_overrun_d;

    logic       sclk_s, csn_s;
    logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic       tx_load, byte_done;
    logic [7:0] new_byte;
    logic       unused_pins;

    assign unused_pins = ^{qspi_i.csn1_o, qspi_i.csn2_o, qspi_i.csn3_o,
                           qspi_i.oen0_o, qspi_i.oen1_o, qspi_i.oen2_o, qspi_i.oen3_o,
                           qspi_i.sd1_o, qspi_i.sd2_o, qspi_i.sd3_o};

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign csn_rise  = csn_s & ~csn_hist_q;
    // A CS already low when reset releases must rise before a fall counts.
    assign csn_fall  = armed_q & ~csn_s & csn_hist_q;
    assign new_byte  = {rx_shift_q, mosi_hist_q};

    always_comb begin
        sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], qspi_i.clk_o};
        csn_sync_d     = {csn_sync_q[SYNC_STAGES-2:0], qspi_i.csn0_o};
        mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], qspi_i.sd0_o};
        flush_d        = {flush_q[SYNC_STAGES-1:0], 1'b1};
        armed_d        = armed_q | (flush_q[SYNC_STAGES] & csn_s & csn_hist_q);
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        load_pending_d = load_pending_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        rx_overrun_d   = 1'b0;
        tx_load        = 1'b0;
        byte_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (csn_fall) begin
                    state_d        = ACTIVE;
                    bit_cnt_d      = 3'd0;
                    load_pending_d = 1'b0;
                    tx_load        = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    state_d        = IDLE;
                    bit_cnt_d      = 3'd0;
                    load_pending_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = new_byte[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done      = 1'b1;
                        load_pending_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (load_pending_q) begin
                        tx_load        = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_valid_i ? tx_data_i : 8'hFF;
        end

        // A byte landing in the same cycle as a consume wins and keeps valid high.
        if (byte_done) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = new_byte;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            sclk_sync_q    <= '0;
            csn_sync_q     <= '1;
            mosi_sync_q    <= '0;
            sclk_hist_q    <= 1'b0;
            csn_hist_q     <= 1'b1;
            mosi_hist_q    <= 1'b0;
            flush_q        <= '0;
            armed_q        <= 1'b0;
            bit_cnt_q      <= 3'd0;
            load_pending_q <= 1'b0;
            rx_shift_q     <= 7'd0;
            tx_shift_q     <= 8'hFF;
            rx_data_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sclk_sync_q    <= sclk_sync_d;
            csn_sync_q     <= csn_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            sclk_hist_q    <= sclk_s;
            csn_hist_q     <= csn_s;
            mosi_hist_q    <= mosi_sync_q[SYNC_STAGES-1];
            flush_q        <= flush_d;
            armed_q        <= armed_d;
            bit_cnt_q      <= bit_cnt_d;
            load_pending_q <= load_pending_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

    assign tx_ready_o    = tx_load & tx_valid_i & ~rst_i;
    assign tx_underrun_o = tx_load & ~tx_valid_i & ~rst_i;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overrun_o  = rx_overrun_q;
    assign cs_active_o   = (state_q == ACTIVE);
    assign qspi_o.sd0_i  = 1'b0;
    assign qspi_o.sd1_i  = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b1;
    assign qspi_o.sd2_i  = 1'b0;
    assign qspi_o.sd3_i  = 1'b0;

endmodule

// File: tb/tb_udma_qspi_target.sv
// tb/tb_udma_qspi_target.sv - directed self-checking bench for udma_qspi_target.
module tb_udma_qspi_target;
    import udma_qspi_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    qspi_to_pad_t qspi_in;
    pad_to_qspi_t qspi_out;
    logic [7:0]   rx_data, tx_data = 8'h00;
    logic         rx_valid, rx_ready = 1'b0, tx_valid = 1'b0;
    logic         tx_ready, cs_active, rx_overrun, tx_underrun;

    int         n_chk = 0, n_err = 0;
    int         n_txr = 0, n_und = 0, n_ovr = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    always_comb begin
        qspi_in        = '0;
        qspi_in.clk_o  = sclk;
        qspi_in.csn0_o = csn;
        qspi_in.sd0_o  = mosi;
    end

    udma_qspi_target #(.SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .qspi_i(qspi_in), .qspi_o(qspi_out),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .cs_active_o(cs_active), .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun)
    );

    always @(negedge clk) begin
        if (tx_ready) n_txr++;
        if (tx_underrun) n_und++;
        if (rx_overrun) n_ovr++;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master side of one byte (or nbits); 'last' drops SCLK and raises CSN together.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] nxt,
                        input bit last, input bit lat, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_clk(5);
            mi[7-i] = qspi_out.sd1_i;
            sclk = 1'b1;
            if (lat && i == 7) begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("rx_valid_2cyc", rx_valid, 1'b0);
                @(posedge clk);
                @(negedge clk);
                check("rx_valid_3cyc", rx_valid, 1'b1);
                wait_clk(2);
            end else begin
                wait_clk(5);
            end
            if (i == 7) tx_data = nxt;
            sclk = 1'b0;
            if (last && i == nbits - 1) csn = 1'b1;
        end
        if (last) wait_clk(8);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m0, m1, m2, m3;
        int         t0, u0, o0, q0;

        wait_clk(4);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_cs_active", cs_active, 1'b0);
        check("rst_miso", qspi_out.sd1_i, 1'b1);
        check("rst_pulses", {tx_ready, rx_overrun, tx_underrun}, 3'b000);
        check("rst_other_sd", {qspi_out.sd0_i, qspi_out.sd2_i, qspi_out.sd3_i}, 3'b000);
        rst = 1'b0;
        wait_clk(10);

        // single byte, rx held then consumed
        tx_data = 8'hA5; tx_valid = 1'b1; t0 = n_txr; u0 = n_und;
        csn = 1'b0;
        xfer(8'h3C, 8, 8'h00, 1'b1, 1'b1, m0);
        check("t1_miso", m0, 8'hA5);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rx_valid", rx_valid, 1'b1);
        check("t1_tx_ready_cnt", n_txr - t0, 1);
        check("t1_underrun_cnt", n_und - u0, 0);
        check("t1_cs_idle", cs_active, 1'b0);
        rx_ready = 1'b1; wait_clk(1); rx_ready = 1'b0; wait_clk(1);
        check("t1_rx_cleared", rx_valid, 1'b0);
        check("t1_rx_hs", rxq[rxq.size()-1], 8'h3C);

        // four-byte burst
        rx_ready = 1'b1; tx_data = 8'h01; tx_valid = 1'b1; t0 = n_txr; q0 = rxq.size();
        csn = 1'b0;
        xfer(8'hDE, 8, 8'h02, 1'b0, 1'b0, m0);
        xfer(8'hAD, 8, 8'h03, 1'b0, 1'b0, m1);
        xfer(8'hBE, 8, 8'h04, 1'b0, 1'b0, m2);
        xfer(8'hEF, 8, 8'h00, 1'b1, 1'b0, m3);
        check("t2_miso", {m0, m1, m2, m3}, 32'h01020304);
        check("t2_rx_cnt", rxq.size() - q0, 4);
        check("t2_rx_bytes", {rxq[q0], rxq[q0+1], rxq[q0+2], rxq[q0+3]}, 32'hDEADBEEF);
        check("t2_tx_ready_cnt", n_txr - t0, 4);

        // underrun
        tx_valid = 1'b0; t0 = n_txr; u0 = n_und; q0 = rxq.size();
        csn = 1'b0;
        xfer(8'h77, 8, 8'h00, 1'b1, 1'b0, m0);
        check("t3_miso", m0, 8'hFF);
        check("t3_underrun_cnt", n_und - u0, 1);
        check("t3_tx_ready_cnt", n_txr - t0, 0);
        check("t3_rx_byte", rxq[rxq.size()-1], 8'h77);

        // overrun
        rx_ready = 1'b0; tx_valid = 1'b1; tx_data = 8'h00; o0 = n_ovr;
        csn = 1'b0;
        xfer(8'h11, 8, 8'h00, 1'b0, 1'b0, m0);
        xfer(8'h22, 8, 8'h00, 1'b1, 1'b0, m1);
        check("t4_rx_data", rx_data, 8'h11);
        check("t4_rx_valid", rx_valid, 1'b1);
        check("t4_overrun_cnt", n_ovr - o0, 1);
        rx_ready = 1'b1; wait_clk(2);
        check("t4_rx_hs", rxq[rxq.size()-1], 8'h11);

        // aborted transfer, then a clean byte
        q0 = rxq.size();
        csn = 1'b0;
        xfer(8'hF0, 5, 8'h00, 1'b1, 1'b0, m0);
        check("t5_no_rx", rxq.size() - q0, 0);
        check("t5_idle", cs_active, 1'b0);
        check("t5_miso_idle", qspi_out.sd1_i, 1'b1);
        csn = 1'b0;
        xfer(8'h5A, 8, 8'h00, 1'b1, 1'b0, m0);
        check("t5_rx_cnt", rxq.size() - q0, 1);
        check("t5_rx_byte", rxq[rxq.size()-1], 8'h5A);

        // reset mid-transfer with CS held low
        tx_data = 8'h00;
        csn = 1'b0;
        xfer(8'hFF, 3, 8'h00, 1'b0, 1'b0, m0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        check("t6_rst_rx_data", rx_data, 8'h00);
        check("t6_rst_flags", {rx_valid, cs_active, tx_ready, rx_overrun, tx_underrun}, 5'b00000);
        check("t6_rst_miso", qspi_out.sd1_i, 1'b1);
        rst = 1'b0;
        t0 = n_txr; u0 = n_und; q0 = rxq.size();
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1; wait_clk(5);
            sclk = 1'b0; wait_clk(5);
        end
        check("t6_ignored_cs", cs_active, 1'b0);
        check("t6_ignored_miso", qspi_out.sd1_i, 1'b1);
        check("t6_ignored_rx", rxq.size() - q0, 0);
        check("t6_ignored_tx", (n_txr - t0) + (n_und - u0), 0);
        csn = 1'b1; wait_clk(10);
        tx_data = 8'h96; t0 = n_txr;
        csn = 1'b0;
        xfer(8'hC3, 8, 8'h00, 1'b1, 1'b0, m0);
        check("t6_miso", m0, 8'h96);
        check("t6_rx_byte", rxq[rxq.size()-1], 8'hC3);
        check("t6_tx_ready_cnt", n_txr - t0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/udma_qspi_target.md
# udma_qspi_target

SPI target (responder) for single-lane, mode-0 traffic issued by the uDMA QSPI master: consumes the master's pad-side outputs (`qspi_to_pad_t`) and returns the MISO line in `pad_to_qspi_t`. SCLK, CSN and MOSI are oversampled in the system clock domain. Received bytes are exposed on a valid/ready stream; transmit bytes are taken from a valid/ready stream. Used for on-chip loopback of SPI channels and as a bench/FPGA peripheral model.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for SCLK/CSN/MOSI (≥2)
- `clk_i`  in  1  system clock; single clock domain
- `rst_i`  in  1  reset, synchronous, active-high
- `qspi_i`  in  `qspi_to_pad_t`  master pad outputs; uses `clk_o` (SCLK), `csn0_o` (CS, active-low), `sd0_o` (MOSI); all other fields ignored
- `qspi_o`  out  `pad_to_qspi_t`  `sd1_i` = MISO; `sd0_i`, `sd2_i`, `sd3_i` tied 0
- `rx_data_o`  out  8  received byte, MSB first on wire
- `rx_valid_o`  out  1  rx byte held
- `rx_ready_i`  in  1  consumer accepts rx byte
- `tx_data_i`  in  8  next byte to shift out
- `tx_valid_i`  in  1  tx byte available
- `tx_ready_o`  out  1  one-cycle pulse: tx byte taken
- `cs_active_o`  out  1  transfer in progress (synced CS low)
- `rx_overrun_o`  out  1  one-cycle pulse: completed byte dropped
- `tx_underrun_o`  out  1  one-cycle pulse: no tx byte at load point, 0xFF sent

## Operation
- SCLK, CSN, MOSI each pass `SYNC_STAGES` flops plus one history flop; rise/fall = sync & ~hist / ~sync & hist.
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on synced CSN fall: bit counter := 0, tx load (below).
- Tx load: if `tx_valid_i`, shift reg := `tx_data_i`, `tx_ready_o` pulse; else shift reg := 0xFF, `tx_underrun_o` pulse. MISO = shift reg MSB.
- ACTIVE, SCLK rise: rx shift := {rx_shift[6:0], MOSI}; counter +1 (3-bit, wraps 7→0). On wrap: byte complete, `load_pending` := 1.
- Byte complete: if `rx_valid_o`=0 or `rx_ready_i`=1 in that cycle, `rx_data_o` := new byte, `rx_valid_o` := 1; else new byte dropped, old byte kept, `rx_overrun_o` pulse.
- ACTIVE, SCLK fall: if `load_pending`, tx load and clear `load_pending`; else tx shift left (fill 1).
- `rx_valid_o` clears on `rx_valid_o & rx_ready_i` unless a new byte lands same cycle (new byte wins, stays 1).
- ACTIVE → IDLE on synced CSN rise, any bit count: partial rx bits discarded, counter := 0, `load_pending` := 0; rx holding register untouched; consumed tx byte lost, no pulse.
- IDLE: SCLK edges ignored; MISO = 1.
- CSN rise and SCLK edge detected same cycle: CSN wins, edge ignored.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, `tx_ready_o`=0, `cs_active_o`=0, `rx_overrun_o`=0, `tx_underrun_o`=0, `qspi_o.sd1_i`=1, other `qspi_o` fields 0; synchronizer flops reset to CSN=1, SCLK=0, MOSI=0; state IDLE.
- Reset mid-transfer: immediate return to IDLE; resumes only after next observed CSN fall (a CS already low at reset release is ignored until it rises and falls).
- Latency (SYNC_STAGES=2): raw pin change → edge detect in 2nd cycle → registered effect visible 3 `clk_i` edges after raw change. Applies to `rx_valid_o` (after 8th SCLK rise), MISO update (after SCLK fall/CSN fall), `cs_active_o`.
- Requirement on master: SCLK high and low phases each ≥ 4 `clk_i` cycles; CSN-fall to first SCLK rise ≥ 4 cycles; MOSI stable ±1 cycle around SCLK rise.
- `tx_data_i` sampled only in the tx-load cycle; `tx_ready_o` high exactly that cycle.

## Test plan
- Reset, CS low, exchange one byte: MOSI 0x3C, `tx_data_i`=0xA5 valid → MISO bits 1,0,1,0,0,1,0,1; `rx_data_o`=0x3C, `rx_valid_o`=1 three cycles after 8th SCLK rise; one `tx_ready_o` pulse.
- 4-byte burst, tx 0x01..0x04, rx 0xDE,0xAD,0xBE,0xEF with `rx_ready_i`=1 → four rx handshakes in order, four `tx_ready_o` pulses, MISO bytes 0x01..0x04.
- `tx_valid_i`=0 at CS fall → MISO 0xFF, one `tx_underrun_o` pulse, no `tx_ready_o`; rx byte still captured.
- `rx_ready_i`=0, two bytes 0x11,0x22 → `rx_data_o` stays 0x11, one `rx_overrun_o` pulse at second byte completion.
- CSN rises after 5 SCLK rises → no rx byte, IDLE, MISO=1; next CS transfer of 0x5A received correctly from bit 0.
- `rst_i` asserted after 3 bits with CS held low → all outputs at reset values; SCLK toggles ignored until CSN rises and falls again; subsequent byte 0xC3 exchanged correctly.
